// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM for the multicycle ARM-subset core.
// Ports: clk, reset (async, active-low), Op/Funct/Rd (held by the IR),
//   mem_ready (used only with CTRL_MEMWAIT_EN), datapath mux selects
//   (AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl), enables
//   (NextPC, IRWrite), raw write requests (RegW, MemW, PCS, FlagW)
//   and an illegal-instruction pulse.
// Optional: define CTRL_MEMWAIT_EN to make FETCH/MEMRD/MEMWR wait on mem_ready.
module multicycle_ctrl_fsm #(
    parameter int CTRL_STATE_W = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic       mem_ready,
    output logic       NextPC,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUControl,
    output logic       RegW,
    output logic       MemW,
    output logic       PCS,
    output logic [1:0] FlagW,
    output logic       illegal
);

    localparam logic [CTRL_STATE_W-1:0] S_FETCH    = CTRL_STATE_W'(0);
    localparam logic [CTRL_STATE_W-1:0] S_DECODE   = CTRL_STATE_W'(1);
    localparam logic [CTRL_STATE_W-1:0] S_MEMADR   = CTRL_STATE_W'(2);
    localparam logic [CTRL_STATE_W-1:0] S_MEMRD    = CTRL_STATE_W'(3);
    localparam logic [CTRL_STATE_W-1:0] S_MEMWB    = CTRL_STATE_W'(4);
    localparam logic [CTRL_STATE_W-1:0] S_MEMWR    = CTRL_STATE_W'(5);
    localparam logic [CTRL_STATE_W-1:0] S_EXECUTER = CTRL_STATE_W'(6);
    localparam logic [CTRL_STATE_W-1:0] S_EXECUTEI = CTRL_STATE_W'(7);
    localparam logic [CTRL_STATE_W-1:0] S_ALUWB    = CTRL_STATE_W'(8);
    localparam logic [CTRL_STATE_W-1:0] S_BRANCH   = CTRL_STATE_W'(9);

    logic [CTRL_STATE_W-1:0] state_q, state_d;

    logic [3:0] cmd;
    logic       is_add, is_sub, is_and, is_orr, is_cmp;
    logic       cmd_ok;
    logic [1:0] alu_cmd;
    logic       rd_pc;
    logic       mem_ok;

    assign cmd    = Funct[4:1];
    assign is_add = (cmd == 4'b0100);
    assign is_sub = (cmd == 4'b0010);
    assign is_and = (cmd == 4'b0000);
    assign is_orr = (cmd == 4'b1100);
    assign is_cmp = (cmd == 4'b1010);
    assign cmd_ok = is_add | is_sub | is_and | is_orr | is_cmp;
    assign rd_pc  = (Rd == 4'd15);

    always_comb begin
        alu_cmd = 2'b00;
        unique case (1'b1)
            is_sub, is_cmp: alu_cmd = 2'b01;
            is_and:         alu_cmd = 2'b10;
            is_orr:         alu_cmd = 2'b11;
            default:        alu_cmd = 2'b00;
        endcase
    end

`ifdef CTRL_MEMWAIT_EN
    assign mem_ok = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (mem_ok) state_d = S_DECODE;
            S_DECODE: begin
                if (Op == 2'b01)
                    state_d = S_MEMADR;
                else if (Op == 2'b00 && cmd_ok)
                    state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                else if (Op == 2'b10)
                    state_d = S_BRANCH;
                else
                    state_d = S_FETCH;
            end
            S_MEMADR:   state_d = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:    if (mem_ok) state_d = S_MEMWB;
            S_MEMWR:    if (mem_ok) state_d = S_FETCH;
            S_EXECUTER,
            S_EXECUTEI: state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        NextPC     = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = 2'b00;
        RegW       = 1'b0;
        MemW       = 1'b0;
        PCS        = 1'b0;
        FlagW      = 2'b00;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ok;
                NextPC    = mem_ok;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                illegal   = (Op == 2'b11) | ((Op == 2'b00) & ~cmd_ok);
            end
            S_MEMADR: ALUSrcB = 2'b01;
            S_MEMRD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
                PCS       = rd_pc;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            S_EXECUTER, S_EXECUTEI: begin
                ALUSrcB    = (state_q == S_EXECUTEI) ? 2'b01 : 2'b00;
                ALUControl = alu_cmd;
                // CMP always updates all flags; otherwise S selects.
                if (is_cmp) FlagW = 2'b11;
                else        FlagW = {Funct[0], Funct[0] & (is_add | is_sub)};
            end
            S_ALUWB: begin
                RegW = ~is_cmp;
                PCS  = rd_pc & ~is_cmp;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCS       = 1'b1;
            end
            default: ;
        endcase
        // Asynchronous reset kills every enable at once; selects already
        // show FETCH because the state register clears asynchronously.
        if (!reset) begin
            NextPC  = 1'b0;
            IRWrite = 1'b0;
            RegW    = 1'b0;
            MemW    = 1'b0;
            PCS     = 1'b0;
            FlagW   = 2'b00;
            illegal = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed testbench for multicycle_ctrl_fsm.
// Walks reset, ADD, LDR-to-PC, CMP, SUB, ORR, illegal, B, STR, reset-in-MEMWR.
module tb_multicycle_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       mem_ready;
    logic       NextPC, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0] ALUSrcB, ResultSrc, ALUControl, FlagW;
    logic       RegW, MemW, PCS, illegal;

    int n_cmp = 0;
    int n_err = 0;

    multicycle_ctrl_fsm dut (
        .clk       (clk),
        .reset     (reset),
        .Op        (Op),
        .Funct     (Funct),
        .Rd        (Rd),
        .mem_ready (mem_ready),
        .NextPC    (NextPC),
        .IRWrite   (IRWrite),
        .AdrSrc    (AdrSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .ALUControl(ALUControl),
        .RegW      (RegW),
        .MemW      (MemW),
        .PCS       (PCS),
        .FlagW     (FlagW),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [3:0] enables();
        return {NextPC, IRWrite, RegW, MemW};
    endfunction

    task automatic instr(input logic [1:0] op, input logic [5:0] f,
                         input logic [3:0] rd);
        Op    = op;
        Funct = f;
        Rd    = rd;
    endtask

    initial begin
        reset     = 1'b0;
        mem_ready = 1'b1;
        instr(2'b00, 6'b000000, 4'd0);

        repeat (3) tick();
        chk("rst_en", enables(), 4'b0000);
        chk("rst_pcs_flag", {PCS, illegal, FlagW}, 4'b0000);
        chk("rst_srcb", {2'b00, ALUSrcB}, 4'b0010);
        chk("rst_srca_adr", {2'b00, ALUSrcA, AdrSrc}, 4'b0010);

        reset = 1'b1;
        #1;
        chk("fetch0_en", {2'b00, NextPC, IRWrite}, 4'b0011);

        // ADD r3, register operand, S=1
        instr(2'b00, 6'b001001, 4'd3);
        tick();
        chk("add_dec", {ALUSrcA, IRWrite, ALUSrcB}, 4'b1010);
        tick();
        chk("add_exr_srcb", {2'b00, ALUSrcB}, 4'b0000);
        chk("add_exr_alu_flag", {ALUControl, FlagW}, 4'b0011);
        tick();
        chk("add_wb", {RegW, PCS, ResultSrc}, 4'b1000);
        tick();
        chk("add_fetch", {2'b00, NextPC, IRWrite}, 4'b0011);

        // LDR to PC
        instr(2'b01, 6'b011001, 4'd15);
        tick();
        tick();
        chk("ldr_adr", {ALUSrcB, ALUControl}, 4'b0100);
        tick();
        chk("ldr_rd", {AdrSrc, RegW, MemW, PCS}, 4'b1000);
        tick();
        chk("ldr_wb", {RegW, PCS, ResultSrc}, 4'b1101);
        tick();
        chk("ldr_fetch", {2'b00, NextPC, IRWrite}, 4'b0011);

        // CMP immediate, S=1
        instr(2'b00, 6'b110101, 4'd0);
        tick();
        tick();
        chk("cmp_exi_srcb", {2'b00, ALUSrcB}, 4'b0001);
        chk("cmp_exi_alu_flag", {ALUControl, FlagW}, 4'b0111);
        tick();
        chk("cmp_wb", {RegW, PCS, MemW, illegal}, 4'b0000);
        tick();

        // CMP register, S=0: flags still forced
        instr(2'b00, 6'b010100, 4'd0);
        tick();
        tick();
        chk("cmp_s0_flag", {2'b00, FlagW}, 4'b0011);
        tick();
        tick();

        // SUB to PC, S=0
        instr(2'b00, 6'b000100, 4'd15);
        tick();
        tick();
        chk("sub_exr", {ALUControl, FlagW}, 4'b0100);
        tick();
        chk("sub_wb", {RegW, PCS, 2'b00}, 4'b1100);
        tick();

        // ORR immediate, S=1: only NZ
        instr(2'b00, 6'b111001, 4'd4);
        tick();
        tick();
        chk("orr_exi", {ALUControl, FlagW}, 4'b1110);
        tick();
        tick();

        // Op 11 illegal: 2 cycles
        instr(2'b11, 6'b001000, 4'd1);
        tick();
        chk("ill_op_dec", {illegal, RegW, IRWrite, PCS}, 4'b1000);
        tick();
        chk("ill_op_fetch", {illegal, 1'b0, NextPC, IRWrite}, 4'b0011);

        // Unsupported cmd (0001) illegal
        instr(2'b00, 6'b000010, 4'd1);
        tick();
        chk("ill_cmd_dec", {3'b000, illegal}, 4'b0001);
        tick();
        chk("ill_cmd_fetch", {2'b00, NextPC, IRWrite}, 4'b0011);

        // Branch: 3 cycles
        instr(2'b10, 6'b000000, 4'd0);
        tick();
        chk("b_dec_ill", {3'b000, illegal}, 4'b0000);
        tick();
        chk("b_br", {PCS, ALUSrcB, ResultSrc[1]}, 4'b1011);
        tick();
        chk("b_fetch", {2'b00, NextPC, IRWrite}, 4'b0011);

        // STR
        instr(2'b01, 6'b011000, 4'd2);
        tick();
        tick();
        tick();
        chk("str_wr", {AdrSrc, MemW, RegW, PCS}, 4'b1100);
`ifdef CTRL_MEMWAIT_EN
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("str_wait_memw", {3'b000, MemW}, 4'b0001);
        end
        mem_ready = 1'b1;
`endif
        tick();
        chk("str_fetch", {2'b00, NextPC, IRWrite}, 4'b0011);

        // Reset during MEMWR
        tick();
        tick();
        tick();
        chk("str2_wr", {3'b000, MemW}, 4'b0001);
        reset = 1'b0;
        #1;
        chk("rst_mid_en", {MemW, RegW, PCS, AdrSrc}, 4'b0000);
        tick();
        reset = 1'b1;
        #1;
        chk("rst_mid_fetch", {ALUSrcA, AdrSrc, NextPC, IRWrite}, 4'b1011);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
